// File: rtl/risc_toy_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, fetch control
// and the decode-side valid/ready pop port.
interface risc_toy_fetch_queue_if #(
    parameter int CW = 3
);
    logic          IREQ;
    logic [29:0]   IADDR;
    logic [31:0]   INSTR;
    logic          EN;
    logic          REDIRECT;
    logic [31:0]   REDIRECT_PC;
    logic          O_VALID;
    logic [31:0]   O_INSTR;
    logic [31:0]   O_PC;
    logic          O_READY;
    logic [CW-1:0] O_COUNT;

    modport master (
        output IREQ, IADDR, O_VALID, O_INSTR, O_PC, O_COUNT,
        input  INSTR, EN, REDIRECT, REDIRECT_PC, O_READY
    );

    modport slave (
        input  IREQ, IADDR, O_VALID, O_INSTR, O_PC, O_COUNT,
        output INSTR, EN, REDIRECT, REDIRECT_PC, O_READY
    );
endinterface

// File: rtl/risc_toy_fetch_queue.sv
// Credit-controlled instruction prefetch for RISC_TOY: fixed-latency memory
// responses land in a DEPTH-entry FIFO that decode pops via valid/ready.
module risc_toy_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_LAT  = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CW       = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    risc_toy_fetch_queue_if.master bus
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          IW      = $clog2(MEM_LAT + 1);
    localparam int          SW      = CW + IW + 1;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    logic                r_run;
    logic [31:0]         r_fetch_pc;
    logic [MEM_LAT-1:0]  r_pipe_vld;
    logic [29:0]         r_pipe_pc [MEM_LAT];
    logic [31:0]         r_fifo_instr [DEPTH];
    logic [31:0]         r_fifo_pc [DEPTH];
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;

    logic [IW-1:0]       w_inflight;
    logic [SW-1:0]       w_credit_used;
    logic                w_ireq;
    logic                w_push;
    logic                w_pop;
    logic [CW-1:0]       w_count_nxt;

    function automatic logic [IW-1:0] f_popcount(input logic [MEM_LAT-1:0] vld);
        logic [IW-1:0] n;
        n = {IW{1'b0}};
        for (int i = 0; i < MEM_LAT; i++) begin
            n = n + IW'(vld[i]);
        end
        return n;
    endfunction

    // Issue credit and FIFO handshake; redirect overrides issue, push and pop
    always_comb begin
        w_inflight    = f_popcount(r_pipe_vld);
        w_credit_used = SW'(r_count) + SW'(w_inflight);
        w_ireq        = r_run & bus.EN & ~bus.REDIRECT & (w_credit_used < SW'(DEPTH));
        w_push        = r_pipe_vld[MEM_LAT-1] & ~bus.REDIRECT;
        w_pop         = (r_count != {CW{1'b0}}) & bus.O_READY & ~bus.REDIRECT;
    end

    // Next FIFO occupancy
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Fetch PC, run flag and fixed-latency response pipe
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC & PC_MASK;
            r_pipe_vld <= {MEM_LAT{1'b0}};
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe_pc[i] <= 30'd0;
            end
        end else begin
            r_run        <= 1'b1;
            r_pipe_pc[0] <= r_fetch_pc[31:2];
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                r_pipe_pc[i] <= r_pipe_pc[i-1];
            end
            if (bus.REDIRECT) begin
                r_fetch_pc <= bus.REDIRECT_PC & PC_MASK;
                r_pipe_vld <= {MEM_LAT{1'b0}};
            end else begin
                r_pipe_vld[0] <= w_ireq;
                for (int i = MEM_LAT - 1; i > 0; i--) begin
                    r_pipe_vld[i] <= r_pipe_vld[i-1];
                end
                if (w_ireq) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end else begin
                    r_fetch_pc <= r_fetch_pc;
                end
            end
        end
    end

    // Instruction FIFO; credit accounting guarantees a push never finds it full
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= 32'd0;
                r_fifo_pc[i]    <= 32'd0;
            end
        end else if (bus.REDIRECT) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_instr[r_tail] <= bus.INSTR;
                r_fifo_pc[r_tail]    <= {r_pipe_pc[MEM_LAT-1], 2'b00};
                r_tail               <= r_tail + PW'(1);
            end else begin
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end else begin
                r_head <= r_head;
            end
            r_count <= w_count_nxt;
        end
    end

    assign bus.IREQ    = w_ireq;
    assign bus.IADDR   = r_fetch_pc[31:2];
    assign bus.O_VALID = (r_count != {CW{1'b0}});
    assign bus.O_INSTR = r_fifo_instr[r_head];
    assign bus.O_PC    = r_fifo_pc[r_head];
    assign bus.O_COUNT = r_count;
endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Randomized bench for risc_toy_fetch_queue against a queue-based model
// of the prefetch rules, plus directed fill/stream/redirect/wrap/reset cases.
module tb_risc_toy_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MEM_LAT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic CLK = 1'b0;
    logic RSTN;

    risc_toy_fetch_queue_if #(.CW(CW)) bus();

    risc_toy_fetch_queue #(
        .DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC), .CW(CW)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: FIFO and in-flight fetches as PC queues
    logic [31:0] m_fifo_pc[$];
    logic [31:0] m_inf_pc[$];
    int          m_inf_due[$];
    logic [31:0] m_fetch_pc;
    bit          m_run;
    int          cyc = 0;
    int          first_ireq = -1;
    int          first_valid = -1;

    // Instruction memory: address-derived data, MEM_LAT cycles after request
    bit          mem_v[MEM_LAT];
    logic [29:0] mem_a[MEM_LAT];

    function automatic logic [31:0] memf(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic run_cycle(input bit en, input bit redir, input logic [31:0] rpc, input bit rdy);
        bit          exp_ireq;
        bit          land;
        logic [31:0] head_pc;
        bus.EN          = en;
        bus.REDIRECT    = redir;
        bus.REDIRECT_PC = rpc;
        bus.O_READY     = rdy;
        bus.INSTR       = mem_v[MEM_LAT-1] ? memf(mem_a[MEM_LAT-1]) : 32'hDEAD_BEEF;
        #2;
        exp_ireq = m_run && en && !redir && ((m_fifo_pc.size() + m_inf_pc.size()) < DEPTH);
        check_eq("ireq", bus.IREQ, exp_ireq);
        if (exp_ireq) check_eq("iaddr", bus.IADDR, m_fetch_pc[31:2]);
        check_eq("o_count", bus.O_COUNT, m_fifo_pc.size());
        check_eq("o_valid", bus.O_VALID, m_fifo_pc.size() != 0);
        if (m_fifo_pc.size() != 0) begin
            head_pc = m_fifo_pc[0];
            check_eq("o_pc", bus.O_PC, head_pc);
            check_eq("o_instr", bus.O_INSTR, memf(head_pc[31:2]));
        end
        check_eq("credit", (int'(bus.O_COUNT) + m_inf_pc.size()) <= DEPTH, 1'b1);
        if (first_ireq < 0 && bus.IREQ) first_ireq = cyc;
        if (first_valid < 0 && bus.O_VALID) first_valid = cyc;

        land = (m_inf_due.size() != 0) && (m_inf_due[0] == cyc);
        if (redir) begin
            m_fifo_pc.delete();
            m_inf_pc.delete();
            m_inf_due.delete();
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (rdy && m_fifo_pc.size() != 0) void'(m_fifo_pc.pop_front());
            if (land) begin
                m_fifo_pc.push_back(m_inf_pc.pop_front());
                void'(m_inf_due.pop_front());
            end
            if (exp_ireq) begin
                m_inf_pc.push_back(m_fetch_pc);
                m_inf_due.push_back(cyc + MEM_LAT);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        m_run = 1'b1;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            mem_v[i] = mem_v[i-1];
            mem_a[i] = mem_a[i-1];
        end
        mem_v[0] = bus.IREQ;
        mem_a[0] = bus.IADDR;
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    // Called between edges: reset must take effect without a clock
    task automatic do_reset();
        RSTN = 1'b0;
        #1;
        check_eq("rst_ireq", bus.IREQ, 1'b0);
        check_eq("rst_valid", bus.O_VALID, 1'b0);
        check_eq("rst_count", bus.O_COUNT, 0);
        check_eq("rst_instr", bus.O_INSTR, 32'd0);
        check_eq("rst_pc", bus.O_PC, 32'd0);
        m_fifo_pc.delete();
        m_inf_pc.delete();
        m_inf_due.delete();
        m_run      = 1'b0;
        m_fetch_pc = RESET_PC & 32'hFFFF_FFFC;
        for (int i = 0; i < MEM_LAT; i++) mem_v[i] = 1'b0;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    logic [31:0] seen[$];
    logic [31:0] wrap_exp[3];
    int          nvalid;
    bit          found;

    initial begin
        RSTN            = 1'b0;
        bus.EN          = 1'b0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = 32'd0;
        bus.O_READY     = 1'b0;
        bus.INSTR       = 32'd0;
        @(posedge CLK);
        #1;
        do_reset();

        // Fill with decode stalled
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("fill_count", bus.O_COUNT, DEPTH);
        check_eq("fill_pc", bus.O_PC, RESET_PC);
        check_eq("latency", first_valid - first_ireq, MEM_LAT + 1);

        // Streaming: no bubbles once filled
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.O_VALID) nvalid++;
            run_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        end
        check_eq("stream_no_bubble", nvalid, 20);

        // Three queued, one in flight, then redirect to an unaligned PC
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("pre_redir_count", bus.O_COUNT, 3);
        run_cycle(1'b1, 1'b1, 32'h0000_2003, 1'b1);
        bus.REDIRECT = 1'b0;
        #1;
        check_eq("redir_valid", bus.O_VALID, 1'b0);
        check_eq("redir_count", bus.O_COUNT, 0);
        check_eq("redir_ireq", bus.IREQ, 1'b1);
        check_eq("redir_iaddr", bus.IADDR, 30'h800);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.O_VALID) begin
                check_eq("redir_first_pc", bus.O_PC, 32'h0000_2000);
                found = 1'b1;
            end
            run_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        end
        check_eq("redir_found", found, 1'b1);

        // PC wrap-around
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        run_cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 20 && seen.size() < 3; i++) begin
            if (bus.O_VALID) seen.push_back(bus.O_PC);
            run_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        end
        check_eq("wrap_n", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) check_eq("wrap_pc", seen[i], wrap_exp[i]);

        // Async reset with two entries queued
        for (int i = 0; i < 60 && m_fifo_pc.size() != 2; i++)
            run_cycle(1'b1, 1'b0, 32'd0, 1'($urandom_range(0, 1)));
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.O_VALID) begin
                check_eq("restart_pc", bus.O_PC, RESET_PC);
                found = 1'b1;
            end
            run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        end
        check_eq("restart_found", found, 1'b1);

        // Random traffic with occasional redirects and resets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF4;
                1:       rpc = 32'h0000_2003;
                default: rpc = $urandom;
            endcase
            if (i % 700 == 699) do_reset();
            else run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                           rpc, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
